fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one synchronous 8-deep FIFO among NREQ producers.

---
 rtl/fifo_wr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin write arbiter with burst lock in front of a FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
   parameter  int NREQ      = 4,
   parameter  int DW        = 8,
   parameter  int CW        = 4,
   parameter  int DEPTH     = 8,
   parameter  int BURST_MAX = 4,
   localparam int OW        = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    i_req,
   input  logic [NREQ*DW-1:0] i_wdata,
   output logic [NREQ-1:0]    o_gnt,
   output logic [DW-1:0]      o_fifo_in,
   output logic               o_fifo_wr_en,
   input  logic [CW-1:0]      i_fifo_counter,
   output logic [OW-1:0]      o_owner,
   output logic               o_stall
);

   localparam int BW = $clog2(BURST_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_STALL = 2'd2
   } state_t;

   state_t          r_state;
   logic [NREQ-1:0] r_gnt;
   logic [DW-1:0]   r_fifo_in;
   logic [OW-1:0]   r_owner;
   logic [BW-1:0]   r_burst;

   logic [NREQ-1:0] w_ereq;
   logic [CW:0]     w_occ;
   logic            w_room;
   logic            w_wr_en;
   logic            w_sticky;
   logic            w_found;
   logic [OW-1:0]   w_win;
   logic [BW-1:0]   w_burst_nxt;

   assign w_wr_en = (r_state == S_GRANT);
   assign w_ereq  = i_req & ~r_gnt;

   // Occupancy includes the write still in flight; a same-cycle pop is ignored.
   assign w_occ  = {1'b0, i_fifo_counter} + (CW+1)'(w_wr_en);
   assign w_room = (w_occ < (CW+1)'(DEPTH));

   // burst_cnt==0 means no burst is in progress, so the reset owner has no claim.
   assign w_sticky = (r_burst != '0) && (int'(r_burst) < BURST_MAX) && w_ereq[r_owner];

   always_comb begin
      w_win   = r_owner;
      w_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_found && w_ereq[(int'(r_owner) + k) % NREQ]) begin
            w_found = 1'b1;
            w_win   = OW'((int'(r_owner) + k) % NREQ);
         end
      end
      if (w_sticky) begin
         w_win = r_owner;
      end
   end

   always_comb begin
      w_burst_nxt = BW'(1);
      if (w_win == r_owner) begin
         w_burst_nxt = (int'(r_burst) < BURST_MAX) ? r_burst + BW'(1) : r_burst;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_fifo_in <= '0;
         r_owner   <= OW'(NREQ - 1);
         r_burst   <= '0;
      end else begin
         r_gnt     <= '0;
         r_fifo_in <= '0;
         case (r_state)
            S_IDLE, S_GRANT, S_STALL: begin
               if (w_ereq == '0) begin
                  r_state <= S_IDLE;
               end else if (w_room) begin
                  r_state   <= S_GRANT;
                  r_gnt     <= NREQ'(1) << w_win;
                  r_fifo_in <= i_wdata[w_win*DW +: DW];
                  r_owner   <= w_win;
                  r_burst   <= w_burst_nxt;
               end else begin
                  r_state <= S_STALL;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_gnt        = r_gnt;
   assign o_fifo_in    = r_fifo_in;
   assign o_fifo_wr_en = w_wr_en;
   assign o_owner      = r_owner;
   assign o_stall      = (r_state == S_STALL);

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed self-checking bench for fifo_wr_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  cnt;

   logic [3:0]  a_gnt,   b_gnt;
   logic [7:0]  a_din,   b_din;
   logic        a_wr,    b_wr;
   logic [1:0]  a_owner, b_owner;
   logic        a_stall, b_stall;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.BURST_MAX(4)) u_dut (
      .clk(clk), .rst(rst), .i_req(req), .i_wdata(wdata),
      .o_gnt(a_gnt), .o_fifo_in(a_din), .o_fifo_wr_en(a_wr),
      .i_fifo_counter(cnt), .o_owner(a_owner), .o_stall(a_stall)
   );

   fifo_wr_arbiter #(.BURST_MAX(1)) u_dut_rr (
      .clk(clk), .rst(rst), .i_req(req), .i_wdata(wdata),
      .o_gnt(b_gnt), .o_fifo_in(b_din), .o_fifo_wr_en(b_wr),
      .i_fifo_counter(cnt), .o_owner(b_owner), .o_stall(b_stall)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("onehot_a", 32'($countones(a_gnt) <= 1), 32'd1);
         check_eq("onehot_b", 32'($countones(b_gnt) <= 1), 32'd1);
         check_eq("wr_full_a", 32'(a_wr && (cnt == 4'd8)), 32'd0);
         check_eq("wren_eq_gnt_a", 32'(a_wr), 32'(|a_gnt));
      end
   end

   initial begin
      logic [3:0] exp_gnt [5];
      logic [7:0] exp_din [5];
      exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_din = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd10};

      // Reset held two cycles with every requester active
      rst = 1'b0; req = 4'b1111; wdata = '0; cnt = 4'd0;
      tick(); tick();
      check_eq("rst_gnt",   32'(a_gnt),   32'd0);
      check_eq("rst_wr",    32'(a_wr),    32'd0);
      check_eq("rst_owner", 32'(a_owner), 32'd3);
      check_eq("rst_stall", 32'(a_stall), 32'd0);
      mon_en = 1'b1;

      // Round robin with BURST_MAX=1
      rst = 1'b1; wdata = {8'd40, 8'd30, 8'd20, 8'd10};
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("rr_gnt%0d", i), 32'(b_gnt), 32'(exp_gnt[i]));
         check_eq($sformatf("rr_din%0d", i), 32'(b_din), 32'(exp_din[i]));
      end

      // Burst: single requester alternates, then rotates after four grants
      rst = 1'b0; req = 4'b0000;
      tick();
      rst = 1'b1; req = 4'b0001; wdata = {8'h00, 8'h5A, 8'h00, 8'hA5};
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq($sformatf("burst_gnt%0d", i), 32'(a_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      check_eq("burst_din", 32'(a_din), 32'd0);
      req = 4'b0101;
      tick();
      check_eq("rot_gnt",   32'(a_gnt),   32'b0100);
      check_eq("rot_din",   32'(a_din),   32'h5A);
      check_eq("rot_owner", 32'(a_owner), 32'd2);

      // FIFO nearly full: one write, stall, then resume when room returns
      rst = 1'b0; req = 4'b0000; cnt = 4'd7;
      tick();
      rst = 1'b1; req = 4'b0001; wdata = 32'h0000_0011;
      tick();
      check_eq("full_gnt1", 32'(a_gnt), 32'd1);
      check_eq("full_wr1",  32'(a_wr),  32'd1);
      tick();
      cnt = 4'd8;
      check_eq("full_gap_wr", 32'(a_wr), 32'd0);
      tick();
      check_eq("full_stall1", 32'(a_stall), 32'd1);
      check_eq("full_wr2",    32'(a_wr),    32'd0);
      tick();
      check_eq("full_stall2", 32'(a_stall), 32'd1);
      cnt = 4'd6;
      tick();
      check_eq("resume_gnt",   32'(a_gnt),   32'd1);
      check_eq("resume_stall", 32'(a_stall), 32'd0);
      check_eq("resume_din",   32'(a_din),   32'h11);

      // Reset asserted while a grant is in flight
      rst = 1'b0; req = 4'b0000; cnt = 4'd0;
      tick();
      rst = 1'b1; req = 4'b0010; wdata = 32'h0000_3300;
      tick();
      check_eq("mid_gnt_pre", 32'(a_gnt), 32'b0010);
      rst = 1'b0;
      tick();
      check_eq("mid_gnt",   32'(a_gnt),   32'd0);
      check_eq("mid_wr",    32'(a_wr),    32'd0);
      check_eq("mid_din",   32'(a_din),   32'd0);
      check_eq("mid_stall", 32'(a_stall), 32'd0);
      check_eq("mid_owner", 32'(a_owner), 32'd3);

      // Withdrawn request never produces a grant
      rst = 1'b1; req = 4'b0000; cnt = 4'd8;
      req = 4'b0100;
      tick();
      check_eq("wd_stall", 32'(a_stall), 32'd1);
      req = 4'b0000; cnt = 4'd0;
      tick();
      check_eq("wd_gnt",   32'(a_gnt),   32'd0);
      check_eq("wd_stall2", 32'(a_stall), 32'd0);
      tick();

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
